// File: rtl/pio_pkg.sv
// Shared constants for the edge-capturing input PIO: register addresses,
// edge-type and interrupt-mode encodings, debounce counter width.
package pio_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA     = 2'd0,
    ADDR_RSVD     = 2'd1,
    ADDR_IRQ_MASK = 2'd2,
    ADDR_EDGE_CAP = 2'd3
  } pio_addr_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

  localparam int DB_CNT_W = 16;

endpackage

// File: rtl/pio_debounce_bit.sv
// One input channel: optional synchroniser chain followed by an optional
// stability filter that only accepts a change held for DEBOUNCE_CYCLES cycles.
module pio_debounce_bit
  import pio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  output logic filtered
);

  logic sync_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync_s = in_bit;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_r;

      // Synchroniser shift chain, cleared by reset.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          sync_r <= '0;
        end else begin
          sync_r[0] <= in_bit;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
          end
        end
      end

      assign sync_s = sync_r[SYNC_STAGES-1];
    end

    if (DEBOUNCE_CYCLES == 0) begin : g_nodb
      assign filtered = sync_s;
    end else begin : g_db
      localparam logic [DB_CNT_W-1:0] LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);
      logic [DB_CNT_W-1:0] cnt_r;
      logic                filt_r;

      // Count consecutive cycles of disagreement; accept the new level on the last one.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          cnt_r  <= '0;
          filt_r <= 1'b0;
        end else if (sync_s == filt_r) begin
          cnt_r  <= '0;
          filt_r <= filt_r;
        end else if (cnt_r == LAST) begin
          cnt_r  <= '0;
          filt_r <= sync_s;
        end else begin
          cnt_r  <= cnt_r + DB_CNT_W'(1);
          filt_r <= filt_r;
        end
      end

      assign filtered = filt_r;
    end
  endgenerate

endmodule

// File: rtl/pio_in_edge_capture.sv
// Avalon-MM input PIO with per-bit synchronise/debounce, edge capture into a
// write-1-to-clear register and a maskable level- or edge-mode interrupt.
module pio_in_edge_capture
  import pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0,
  parameter int IRQ_MODE        = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] filtered_s;
  logic [WIDTH-1:0] prev_r;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] irq_mask_r;
  logic [WIDTH-1:0] edge_cap_r;
  logic [WIDTH-1:0] irq_src_s;
  logic [31:0]      rd_mux_s;
  logic             wr_s;
  logic             unused_wdata_s;

  generate
    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      pio_debounce_bit #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_bit (
        .clk     (clk),
        .reset_n (reset_n),
        .in_bit  (in_port[g]),
        .filtered(filtered_s[g])
      );
    end
  endgenerate

  assign wr_s           = chipselect & ~write_n;
  assign unused_wdata_s = ^writedata;

  // Edge selection from the filtered value and its one-cycle-old copy.
  always_comb begin
    edge_s = '0;
    case (EDGE_TYPE)
      EDGE_RISE: edge_s = filtered_s & ~prev_r;
      EDGE_FALL: edge_s = ~filtered_s & prev_r;
      EDGE_ANY:  edge_s = filtered_s ^ prev_r;
      default:   edge_s = filtered_s & ~prev_r;
    endcase
  end

  // Previous value, mask and capture registers; a new edge beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_r     <= '0;
      irq_mask_r <= '0;
      edge_cap_r <= '0;
    end else begin
      prev_r <= filtered_s;
      if (wr_s && (pio_addr_e'(address) == ADDR_IRQ_MASK)) begin
        irq_mask_r <= writedata[WIDTH-1:0];
      end else begin
        irq_mask_r <= irq_mask_r;
      end
      if (wr_s && (pio_addr_e'(address) == ADDR_EDGE_CAP)) begin
        edge_cap_r <= (edge_cap_r & ~writedata[WIDTH-1:0]) | edge_s;
      end else begin
        edge_cap_r <= edge_cap_r | edge_s;
      end
    end
  end

  // Read mux; unused upper bits stay zero.
  always_comb begin
    rd_mux_s = 32'd0;
    case (pio_addr_e'(address))
      ADDR_DATA:     rd_mux_s[WIDTH-1:0] = filtered_s;
      ADDR_RSVD:     rd_mux_s = 32'd0;
      ADDR_IRQ_MASK: rd_mux_s[WIDTH-1:0] = irq_mask_r;
      ADDR_EDGE_CAP: rd_mux_s[WIDTH-1:0] = edge_cap_r;
      default:       rd_mux_s = 32'd0;
    endcase
  end

  // Read data register, refreshed every cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata <= 32'd0;
    end else begin
      readdata <= rd_mux_s;
    end
  end

  assign irq_src_s = (IRQ_MODE == IRQ_LEVEL) ? filtered_s : edge_cap_r;
  assign irq       = |(irq_src_s & irq_mask_r);

endmodule

// File: tb/tb_pio_in_edge_capture.sv
// Self-checking bench: four PIO instances in different configurations share
// one bus; reads go through a scoreboard queue, irq is checked directly.
module tb_pio_in_edge_capture;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [3:0]  in_a = 4'd0, in_b = 4'd0, in_c = 4'd0, in_d = 4'd0;
  logic [31:0] rdata [4];
  logic [3:0]  irqs;

  int n_err = 0;
  int n_checks = 0;

  typedef struct {
    int          dut;
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t tbl[12];

  always #5 clk = ~clk;

  // a: defaults (N=0, rising, edge irq)
  pio_in_edge_capture #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0), .IRQ_MODE(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_a), .readdata(rdata[0]), .irq(irqs[0]));
  // b: debounce of 4 cycles
  pio_in_edge_capture #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .IRQ_MODE(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_b), .readdata(rdata[1]), .irq(irqs[1]));
  // c: any-edge capture
  pio_in_edge_capture #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2), .IRQ_MODE(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_c), .readdata(rdata[2]), .irq(irqs[2]));
  // d: level-mode interrupt
  pio_in_edge_capture #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0), .IRQ_MODE(0)) dut_d (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_d), .readdata(rdata[3]), .irq(irqs[3]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_write(logic [1:0] a, logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic do_read(int d, logic [1:0] a, logic [31:0] e, string nm);
    sb_t r;
    address = a; chipselect = 1'b1; write_n = 1'b1;
    r.dut = d; r.exp = e; r.name = nm;
    sb_q.push_back(r);
    tick();
    chipselect = 1'b0;
    r = sb_q.pop_front();
    check(r.name, rdata[r.dut], r.exp);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 2'd0, 32'd0,          32'd0,   "rst_data"};
    tbl[1]  = '{1'b0, 2'd1, 32'd0,          32'd0,   "rst_rsvd"};
    tbl[2]  = '{1'b0, 2'd2, 32'd0,          32'd0,   "rst_mask"};
    tbl[3]  = '{1'b0, 2'd3, 32'd0,          32'd0,   "rst_ecap"};
    tbl[4]  = '{1'b1, 2'd2, 32'h0000_000F,  32'd0,   "wr_mask"};
    tbl[5]  = '{1'b0, 2'd2, 32'd0,          32'h0F,  "mask_rb"};
    tbl[6]  = '{1'b1, 2'd0, 32'h0000_000A,  32'd0,   "wr_data"};
    tbl[7]  = '{1'b0, 2'd0, 32'd0,          32'd0,   "data_ro"};
    tbl[8]  = '{1'b1, 2'd2, 32'hFFFF_FFFF,  32'd0,   "wr_mask_hi"};
    tbl[9]  = '{1'b0, 2'd2, 32'd0,          32'h0F,  "mask_hi_bits"};
    tbl[10] = '{1'b1, 2'd1, 32'h0000_0005,  32'd0,   "wr_rsvd"};
    tbl[11] = '{1'b0, 2'd1, 32'd0,          32'd0,   "rsvd_rd"};

    repeat (3) tick();
    check("irq_in_reset", {28'd0, irqs}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].wdata);
      else           do_read(0, tbl[i].addr, tbl[i].exp, tbl[i].name);
    end
    check("irq_idle", {28'd0, irqs}, 32'd0);

    // a: rising edges, DATA after 3 cycles, capture one cycle later, W1C clears irq
    in_a = 4'b0101;
    tick(); tick();
    check("a_irq_pre", {31'd0, irqs[0]}, 32'd0);
    do_read(0, 2'd0, 32'h5, "a_data");
    do_read(0, 2'd3, 32'h5, "a_ecap");
    check("a_irq_set", {31'd0, irqs[0]}, 32'd1);
    repeat (3) tick();
    check("a_irq_hold", {31'd0, irqs[0]}, 32'd1);
    do_write(2'd3, 32'h5);
    check("a_irq_clr", {31'd0, irqs[0]}, 32'd0);
    do_read(0, 2'd3, 32'h0, "a_ecap_clr");

    // b: 3-cycle glitch rejected, 4-cycle pulse accepted exactly on time
    in_b = 4'b0001;
    repeat (3) tick();
    in_b = 4'b0000;
    repeat (8) tick();
    do_read(1, 2'd0, 32'h0, "b_glitch_data");
    do_read(1, 2'd3, 32'h0, "b_glitch_ecap");
    in_b = 4'b0001;
    repeat (4) tick();
    in_b = 4'b0000;
    tick();
    do_read(1, 2'd0, 32'h0, "b_data_early");
    do_read(1, 2'd0, 32'h1, "b_data_4");
    do_read(1, 2'd3, 32'h1, "b_ecap");
    check("b_irq", {31'd0, irqs[1]}, 32'd1);
    repeat (6) tick();
    do_write(2'd3, 32'hF);

    // c: any-edge capture, W1C between edges, W1C racing a new edge
    in_c = 4'b0010;
    repeat (3) tick();
    do_read(2, 2'd3, 32'h2, "c_rise");
    do_write(2'd3, 32'h2);
    do_read(2, 2'd3, 32'h0, "c_w1c");
    in_c = 4'b0000;
    repeat (3) tick();
    do_read(2, 2'd3, 32'h2, "c_fall");
    do_write(2'd3, 32'h2);
    do_read(2, 2'd3, 32'h0, "c_w1c2");
    in_c = 4'b0010;
    tick(); tick();
    do_write(2'd3, 32'h2);
    do_read(2, 2'd3, 32'h2, "c_w1c_race");

    // d: level-mode irq follows DATA bit3 under mask 0x8
    do_write(2'd2, 32'h8);
    in_d = 4'b0001;
    repeat (3) tick();
    check("d_irq_other_bit", {31'd0, irqs[3]}, 32'd0);
    in_d = 4'b1001;
    tick();
    check("d_irq_pre", {31'd0, irqs[3]}, 32'd0);
    tick();
    check("d_irq_lvl", {31'd0, irqs[3]}, 32'd1);
    in_d = 4'b0001;
    tick();
    check("d_irq_hold", {31'd0, irqs[3]}, 32'd1);
    tick();
    check("d_irq_fall", {31'd0, irqs[3]}, 32'd0);
    do_write(2'd2, 32'h0);
    in_d = 4'b1111;
    repeat (3) tick();
    check("d_irq_mask0", {31'd0, irqs[3]}, 32'd0);

    // reset with capture=0xF, mask=0xF and a debounce count in progress
    do_write(2'd3, 32'hF);
    in_a = 4'b0000;
    repeat (3) tick();
    do_write(2'd2, 32'hF);
    in_a = 4'b1111;
    in_b = 4'b0001;
    repeat (3) tick();
    do_read(0, 2'd3, 32'hF, "pre_rst_ecap");
    check("pre_rst_irq", {31'd0, irqs[0]}, 32'd1);
    address = 2'd3;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("rst_rdata", rdata[0], 32'd0);
    check("rst_irq_all", {28'd0, irqs}, 32'd0);
    do_read(0, 2'd0, 32'h0, "post_rst_data");
    do_read(0, 2'd2, 32'h0, "post_rst_mask");
    do_read(0, 2'd3, 32'h0, "post_rst_ecap");
    do_read(0, 2'd3, 32'hF, "post_rst_recap");
    check("post_rst_irq_off", {31'd0, irqs[0]}, 32'd0);
    do_read(1, 2'd0, 32'h0, "post_rst_b_early");
    do_read(1, 2'd0, 32'h0, "post_rst_b_fresh");
    do_read(1, 2'd0, 32'h1, "post_rst_b_data");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
